// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift unit, one LSL/LSR/ASR step per clock with start/busy/done handshake
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted when not busy (IDLE or DONE)
//   A      operand, captured on accepted start
//   AMT    shift count, captured on accepted start
//   LA     1 = arithmetic (right shifts only), 0 = logical
//   LR     0 = left, 1 = right
//   Y      result register, held until the next accepted start
//   C      last bit shifted out, 0 when AMT == 0
//   V      always 0
//   Z      Y == 0, registered alongside Y
//   busy   high while shifting
//   done   one-cycle pulse, Y/C/Z valid from this cycle
module shift_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [WIDTH-1:0]           A,
   input  logic [$clog2(WIDTH)-1:0]   AMT,
   input  logic                       LA,
   input  logic                       LR,
   output logic [WIDTH-1:0]           Y,
   output logic                       C,
   output logic                       V,
   output logic                       Z,
   output logic                       busy,
   output logic                       done
);
   localparam int AMT_W = $clog2(WIDTH);
   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] amt_sat;
   logic             la_q;
   logic             lr_q;
   logic             accept;
   logic [WIDTH-1:0] step_y;
   logic             step_c;
   logic [WIDTH-1:0] y_nxt;
   logic             c_nxt;

   // counts beyond WIDTH-1 only exist when WIDTH is not a power of two
   if ((1 << AMT_W) > WIDTH) begin : g_sat
      assign amt_sat = (AMT > AMT_MAX) ? AMT_MAX : AMT;
   end else begin : g_nosat
      assign amt_sat = AMT;
   end

   assign accept = start && (state != SHIFT);
   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
   assign V      = 1'b0;

   always_comb begin
      step_y = lr_q ? {la_q & Y[WIDTH-1], Y[WIDTH-1:1]} : {Y[WIDTH-2:0], 1'b0};
      step_c = lr_q ? Y[0] : Y[WIDTH-1];
      y_nxt  = accept ? A : (busy ? step_y : Y);
      c_nxt  = accept ? 1'b0 : (busy ? step_c : C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         la_q  <= 1'b0;
         lr_q  <= 1'b0;
         Y     <= '0;
         C     <= 1'b0;
         Z     <= 1'b0;
      end else begin
         Y <= y_nxt;
         C <= c_nxt;
         Z <= (y_nxt == '0);
         if (accept) begin
            cnt   <= amt_sat;
            la_q  <= LA;
            lr_q  <= LR;
            state <= (amt_sat == '0) ? DONE : SHIFT;
         end else if (state == SHIFT) begin
            cnt   <= cnt - 1'b1;
            state <= (cnt == AMT_W'(1)) ? DONE : SHIFT;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer with a result scoreboard
module tb_shift_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [2:0] AMT = '0;
   logic       LA = 1'b0;
   logic       LR = 1'b0;
   logic [7:0] Y;
   logic       C, V, Z, busy, done;

   typedef struct {logic [7:0] y; logic c; logic z;} exp_t;
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   shift_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .AMT(AMT), .LA(LA), .LR(LR),
      .Y(Y), .C(C), .V(V), .Z(Z), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [7:0] a, input int amt, input logic la, input logic lr);
      logic [7:0] y = a;
      logic       c = 1'b0;
      for (int i = 0; i < amt; i++) begin
         if (!lr) begin c = y[7]; y = y << 1; end
         else begin c = y[0]; y = {la ? y[7] : 1'b0, y[7:1]}; end
      end
      return {c, y};
   endfunction

   task automatic run(input string tag, input logic [7:0] a, input logic [2:0] amt,
                      input logic la, input logic lr, input logic [7:0] ey, input logic ec,
                      input bit glitch);
      int   lat = 0;
      int   bcyc = 0;
      exp_t e;
      @(negedge clk);
      start = 1'b1; A = a; AMT = amt; LA = la; LR = lr;
      sb.push_back('{y: ey, c: ec, z: (ey == 8'h00)});
      @(posedge clk); #1;
      start = 1'b0; A = 8'h00; AMT = 3'd0; LA = ~la; LR = ~lr;
      while (!done && lat < 40) begin
         if (busy) bcyc++;
         if (glitch && lat == 2) begin start = 1'b1; A = 8'hFF; AMT = 3'd1; end
         else start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, lat, amt);
      chk({tag, "_busy_cycles"}, bcyc, amt);
      e = sb.pop_front();
      chk({tag, "_Y"}, Y, e.y);
      chk({tag, "_C"}, C, e.c);
      chk({tag, "_Z"}, Z, e.z);
      chk({tag, "_V"}, V, 0);
   endtask

   task automatic idle_check(input string tag, input logic [7:0] ey, input logic ec);
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, done, 0);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_Y_hold"}, Y, ey);
      chk({tag, "_C_hold"}, C, ec);
   endtask

   initial begin
      logic [8:0] m;
      logic [7:0] ra;
      logic [2:0] ramt;
      logic       rla, rlr;
      #12;
      chk("reset_Y", Y, 0);
      chk("reset_C", C, 0);
      chk("reset_Z", Z, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk); rst_n = 1'b1;

      run("t1_lsl1", 8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 0);
      idle_check("t1", 8'h02, 1'b1);
      run("t2_asr3", 8'h80, 3'd3, 1'b1, 1'b1, 8'hF0, 1'b0, 0);
      idle_check("t2", 8'hF0, 1'b0);
      run("t2_lsr3", 8'h80, 3'd3, 1'b0, 1'b1, 8'h10, 1'b0, 0);
      idle_check("t2b", 8'h10, 1'b0);
      run("t3_amt0", 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 0);
      idle_check("t3", 8'h5A, 1'b0);
      run("t4_lsr7_glitch", 8'hB5, 3'd7, 1'b0, 1'b1, 8'h01, 1'b0, 1);
      idle_check("t4", 8'h01, 1'b0);
      run("t5_lsr1", 8'h01, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1, 0);
      run("t5_b2b_lsl7", 8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0, 0);
      idle_check("t5", 8'h80, 1'b0);
      run("b2b_amt0_a", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
      run("b2b_amt0_b", 8'hC3, 3'd0, 1'b1, 1'b1, 8'hC3, 1'b0, 0);
      idle_check("b2b0", 8'hC3, 1'b0);

      @(negedge clk);
      start = 1'b1; A = 8'hFF; AMT = 3'd5; LA = 1'b0; LR = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk("t6_busy_before_reset", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_Y", Y, 0);
      chk("t6_async_C", C, 0);
      chk("t6_async_Z", Z, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_done", done, 0);
      run("t6_after_reset", 8'h0F, 3'd4, 1'b1, 1'b0, 8'hF0, 1'b0, 0);
      idle_check("t6", 8'hF0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom); ramt = 3'($urandom_range(0, 7));
         rla = 1'($urandom); rlr = 1'($urandom);
         m = model(ra, int'(ramt), rla, rlr);
         run($sformatf("rnd%0d", i), ra, ramt, rla, rlr, m[7:0], m[8], 0);
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
